// File: rtl/fmul36_pkg.sv
// Shared number-format definitions for the 36-bit float multiplier interface.
package fmul36_pkg;

    localparam int WIDTH    = 36;
    localparam int SIGN_BIT = 35;
    localparam int EXP_MSB  = 34;
    localparam int EXP_LSB  = 24;
    localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;
    localparam int FRAC_W   = 24;
    localparam int EXP_BIAS = 1023;
    localparam logic [EXP_W-1:0] EXP_MAX = 11'h7ff;

    // Field view of one 36-bit value: {sign, exponent, fraction}.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  expo;
        logic [FRAC_W-1:0] frac;
    } fmul36_t;

    // Result classification, ordered {nan, inf, zero}.
    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fmul36_flags_t;

    // Exponent-driven classification; subnormals count as zero.
    function automatic fmul36_flags_t f_classify(input fmul36_t v);
        fmul36_flags_t f;
        f.zero = (v.expo == '0);
        f.inf  = (v.expo == EXP_MAX) && (v.frac == '0);
        f.nan  = (v.expo == EXP_MAX) && (v.frac != '0);
        return f;
    endfunction

endpackage

// File: rtl/fmul36_result_fifo.sv
// Synchronous result FIFO with occupancy count; head data reads as zero when empty.
module fmul36_result_fifo
    import fmul36_pkg::*;
#(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic [P_DEPTH_N:0]   count,
    output logic                 full,
    output logic                 empty
);

    logic [WIDTH-1:0]     mem [P_DEPTH];
    logic [P_DEPTH_N-1:0] wr_ptr;
    logic [P_DEPTH_N-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (P_DEPTH_N+1)'(P_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array; no reset needed because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fmul36_issue_ctrl.sv
// Issue controller: one-entry operand register, credit-limited issue to the
// multiplier, result FIFO with classification, sticky unexpected-result flag.
// Handshake: on every port a transfer happens at a rising edge where the
// request/valid is 1 and the matching busy is 0.
module fmul36_issue_ctrl
    import fmul36_pkg::*;
#(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
) (
    input  logic             iCLOCK,
    input  logic             iRESET,
    input  logic             iRESET_SYNC,
    input  logic             iOP_REQ,
    output logic             oOP_BUSY,
    input  logic [WIDTH-1:0] iOP_A,
    input  logic [WIDTH-1:0] iOP_B,
    output logic             oMUL_REQ,
    input  logic             iMUL_BUSY,
    output logic [WIDTH-1:0] oMUL_A,
    output logic [WIDTH-1:0] oMUL_B,
    input  logic             iMUL_VALID,
    output logic             oMUL_BUSY,
    input  logic [WIDTH-1:0] iMUL_DATA,
    output logic             oRES_VALID,
    input  logic             iRES_BUSY,
    output logic [WIDTH-1:0] oRES_DATA,
    output logic [2:0]       oRES_FLAGS,
    output logic             oERR_UNEXPECTED
);

    localparam int CNT_W = P_DEPTH_N + 1;
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(P_DEPTH);

    logic              op_valid;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W:0]    occupancy;
    logic              credit_ok;
    logic              op_fire;
    logic              issue_fire;
    logic              res_fire;
    logic              capture;
    logic              unexpected;
    logic              pop;
    logic              err;

    // Credit covers both results still in the multiplier and results queued,
    // so the FIFO can always absorb every result that is owed.
    assign occupancy  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok  = (occupancy < DEPTH_LIM);

    assign oMUL_REQ   = op_valid & credit_ok;
    assign issue_fire = oMUL_REQ & ~iMUL_BUSY;
    assign oOP_BUSY   = op_valid & ~issue_fire;
    assign op_fire    = iOP_REQ & ~oOP_BUSY;
    assign oMUL_A     = op_a;
    assign oMUL_B     = op_b;

    assign oMUL_BUSY  = fifo_full;
    assign res_fire   = iMUL_VALID & ~oMUL_BUSY;
    assign capture    = res_fire & (outstanding != '0);
    assign unexpected = res_fire & (outstanding == '0);

    assign oRES_VALID = ~fifo_empty;
    assign pop        = oRES_VALID & ~iRES_BUSY;
    assign oERR_UNEXPECTED = err;
    assign oRES_FLAGS = f_classify(oRES_DATA);

    // Operand register: refill allowed in the same cycle the held pair issues.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else if (iRESET_SYNC) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else if (op_fire) begin
            op_valid <= 1'b1;
            op_a     <= iOP_A;
            op_b     <= iOP_B;
        end else if (issue_fire) begin
            op_valid <= 1'b0;
        end
    end

    // In-flight counter: +1 per issue, -1 per accepted result.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            outstanding <= '0;
        end else if (iRESET_SYNC) begin
            outstanding <= '0;
        end else begin
            case ({issue_fire, capture})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky flag for results the controller never asked for; data is dropped.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET)           err <= 1'b0;
        else if (iRESET_SYNC) err <= 1'b0;
        else if (unexpected)  err <= 1'b1;
    end

    fmul36_result_fifo #(
        .P_DEPTH   (P_DEPTH),
        .P_DEPTH_N (P_DEPTH_N)
    ) u_fifo (
        .clk   (iCLOCK),
        .rst   (iRESET),
        .clr   (iRESET_SYNC),
        .push  (capture),
        .pop   (pop),
        .din   (iMUL_DATA),
        .dout  (oRES_DATA),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_fmul36_issue_ctrl.sv
// Directed bench for fmul36_issue_ctrl with a latency-1 multiplier model.
module tb_fmul36_issue_ctrl;

    logic        iCLOCK;
    logic        iRESET;
    logic        iRESET_SYNC;
    logic        iOP_REQ;
    logic        oOP_BUSY;
    logic [35:0] iOP_A;
    logic [35:0] iOP_B;
    logic        oMUL_REQ;
    logic        iMUL_BUSY;
    logic [35:0] oMUL_A;
    logic [35:0] oMUL_B;
    logic        iMUL_VALID;
    logic        oMUL_BUSY;
    logic [35:0] iMUL_DATA;
    logic        oRES_VALID;
    logic        iRES_BUSY;
    logic [35:0] oRES_DATA;
    logic [2:0]  oRES_FLAGS;
    logic        oERR_UNEXPECTED;

    fmul36_issue_ctrl #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
        .iCLOCK          (iCLOCK),
        .iRESET          (iRESET),
        .iRESET_SYNC     (iRESET_SYNC),
        .iOP_REQ         (iOP_REQ),
        .oOP_BUSY        (oOP_BUSY),
        .iOP_A           (iOP_A),
        .iOP_B           (iOP_B),
        .oMUL_REQ        (oMUL_REQ),
        .iMUL_BUSY       (iMUL_BUSY),
        .oMUL_A          (oMUL_A),
        .oMUL_B          (oMUL_B),
        .iMUL_VALID      (iMUL_VALID),
        .oMUL_BUSY       (oMUL_BUSY),
        .iMUL_DATA       (iMUL_DATA),
        .oRES_VALID      (oRES_VALID),
        .iRES_BUSY       (iRES_BUSY),
        .oRES_DATA       (oRES_DATA),
        .oRES_FLAGS      (oRES_FLAGS),
        .oERR_UNEXPECTED (oERR_UNEXPECTED)
    );

    // ---------------- clock ----------------
    initial begin
        iCLOCK = 1'b0;
        forever #5 iCLOCK = ~iCLOCK;
    end

    // ---------------- counters and check ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    // ---------------- multiplier model ----------------
    // Exact for zero-fraction normal operands; a special-exponent A is echoed.
    function automatic logic [35:0] mul_model(input logic [35:0] a, input logic [35:0] b);
        logic [10:0] ea;
        logic [10:0] eb;
        logic [11:0] es;
        ea = a[34:24];
        eb = b[34:24];
        es = {1'b0, ea} + {1'b0, eb} - 12'd1023;
        if (ea == 11'h7ff || ea == 11'h000) return a;
        return {a[35] ^ b[35], es[10:0], 24'h0};
    endfunction

    bit          mul_en;
    bit          mdl_hold;
    bit          rand_busy;
    logic        mdl_valid;
    logic [35:0] mdl_data;
    logic        man_valid;
    logic [35:0] man_data;
    logic [35:0] mq[$];
    int          issue_cnt;
    bit          will_issue;
    bit          will_cap;
    logic [35:0] iss_a;
    logic [35:0] iss_b;
    bit          hold_prev;
    logic [35:0] hold_a;
    logic [35:0] hold_b;

    assign iMUL_VALID = mul_en ? mdl_valid : man_valid;
    assign iMUL_DATA  = mul_en ? mdl_data  : man_data;

    // Decide at the falling edge what the next rising edge will transfer;
    // also check that a stalled request keeps its operands.
    always @(negedge iCLOCK) begin
        will_issue = !iRESET && oMUL_REQ && !iMUL_BUSY;
        will_cap   = mul_en && !iRESET && iMUL_VALID && !oMUL_BUSY;
        iss_a = oMUL_A;
        iss_b = oMUL_B;
        if (hold_prev && !iRESET) begin
            chk("mul_a_stable", oMUL_A, hold_a);
            chk("mul_b_stable", oMUL_B, hold_b);
            chk("mul_req_held", oMUL_REQ, 1);
        end
        hold_prev = !iRESET && oMUL_REQ && iMUL_BUSY;
        hold_a = oMUL_A;
        hold_b = oMUL_B;
    end

    // Apply transfers just after the rising edge and present the next result.
    always @(posedge iCLOCK) begin
        #1;
        if (will_cap && mq.size() != 0) void'(mq.pop_front());
        if (will_issue) begin
            mq.push_back(mul_model(iss_a, iss_b));
            issue_cnt++;
        end
        mdl_valid = !mdl_hold && (mq.size() != 0);
        mdl_data  = (mq.size() != 0) ? mq[0] : 36'h0;
    end

    // Random multiplier stall.
    always @(posedge iCLOCK) begin
        #1;
        iMUL_BUSY = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // ---------------- scoreboard ----------------
    logic [35:0] exp_q[$];
    logic [2:0]  exp_f_q[$];

    always @(negedge iCLOCK) begin
        if (!iRESET && oRES_VALID && !iRES_BUSY) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL res_extra: observed %0h expected no result", oRES_DATA);
            end else begin
                chk("res_data", oRES_DATA, exp_q.pop_front());
                chk("res_flags", oRES_FLAGS, exp_f_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_op(input logic [35:0] a, input logic [35:0] b,
                           input logic [35:0] exp_d, input logic [2:0] exp_f, input bit track);
        bit acc;
        int n;
        iOP_A = a;
        iOP_B = b;
        iOP_REQ = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge iCLOCK);
            acc = !oOP_BUSY;
            @(posedge iCLOCK);
            #1;
            n++;
        end
        iOP_REQ = 1'b0;
        chk("op_accept", 64'(acc), 1);
        if (acc && track) begin
            exp_q.push_back(exp_d);
            exp_f_q.push_back(exp_f);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mq.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_op_busy", oOP_BUSY, 0);
        chk("rst_mul_req", oMUL_REQ, 0);
        chk("rst_mul_a", oMUL_A, 0);
        chk("rst_mul_b", oMUL_B, 0);
        chk("rst_mul_busy", oMUL_BUSY, 0);
        chk("rst_res_valid", oRES_VALID, 0);
        chk("rst_res_data", oRES_DATA, 0);
        chk("rst_res_flags", oRES_FLAGS, 3'b001);
        chk("rst_err", oERR_UNEXPECTED, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [35:0] a;
        logic [35:0] b;
        iRESET = 1'b0; iRESET_SYNC = 1'b0; iOP_REQ = 1'b0; iOP_A = '0; iOP_B = '0;
        iRES_BUSY = 1'b0; man_valid = 1'b0; man_data = '0;
        mul_en = 1'b1; mdl_hold = 1'b0; rand_busy = 1'b0;
        mdl_valid = 1'b0; mdl_data = '0; iMUL_BUSY = 1'b0; issue_cnt = 0; hold_prev = 1'b0;
        #1 iRESET = 1'b1;
        #1 check_reset_outputs();
        tick();
        iRESET = 1'b0;
        tick();

        // Basic products, idle downstream.
        send_op(36'h3ff000000, 36'h3ff000000, 36'h3ff000000, 3'b000, 1);
        chk("req_latency", oMUL_REQ, 1);
        send_op(36'h3ff000000, 36'h400000000, 36'h400000000, 3'b000, 1);
        send_op(36'h3fe000000, 36'h400000000, 36'h3ff000000, 3'b000, 1);
        wait_drain();

        // Credit limit with downstream stalled.
        iRES_BUSY = 1'b1;
        issue_cnt = 0;
        send_op(36'h3ff000000, 36'h400000000, 36'h400000000, 3'b000, 1);
        send_op(36'h3ff000000, 36'h401000000, 36'h401000000, 3'b000, 1);
        send_op(36'h3ff000000, 36'h402000000, 36'h402000000, 3'b000, 1);
        send_op(36'h3ff000000, 36'h403000000, 36'h403000000, 3'b000, 1);
        send_op(36'h3ff000000, 36'h404000000, 36'h404000000, 3'b000, 1);
        iOP_A = 36'h3ff000000; iOP_B = 36'h405000000; iOP_REQ = 1'b1;
        repeat (10) tick();
        chk("credit_issue_cnt", 64'(issue_cnt), 4);
        chk("credit_req_low", oMUL_REQ, 0);
        chk("credit_op_busy", oOP_BUSY, 1);
        chk("credit_fifo_full", oMUL_BUSY, 1);
        chk("credit_res_valid", oRES_VALID, 1);
        iRES_BUSY = 1'b0;
        tick();
        chk("credit_req_reenable", oMUL_REQ, 1);
        send_op(36'h3ff000000, 36'h405000000, 36'h405000000, 3'b000, 1);
        wait_drain();
        chk("credit_total_issues", 64'(issue_cnt), 6);

        // Random multiplier and downstream stalls.
        rand_busy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = {1'($urandom_range(0, 1)), 11'($urandom_range(11'h3f0, 11'h40f)), 24'h0};
            b = {1'($urandom_range(0, 1)), 11'($urandom_range(11'h3f0, 11'h40f)), 24'h0};
            iRES_BUSY = ($urandom_range(0, 3) == 0);
            send_op(a, b, mul_model(a, b), 3'b000, 1);
        end
        iRES_BUSY = 1'b0;
        rand_busy = 1'b0;
        wait_drain();

        // Classification of special results.
        send_op(36'h7ff000000, 36'h3ff000000, 36'h7ff000000, 3'b010, 1);
        send_op(36'h7ff000001, 36'h3ff000000, 36'h7ff000001, 3'b100, 1);
        send_op(36'h000000000, 36'h3ff000000, 36'h000000000, 3'b001, 1);
        wait_drain();

        // Unexpected result with nothing outstanding.
        repeat (2) tick();
        mul_en = 1'b0;
        man_data = 36'h123456789;
        man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        chk("err_set", oERR_UNEXPECTED, 1);
        chk("err_no_push", oRES_VALID, 0);
        repeat (3) tick();
        chk("err_sticky", oERR_UNEXPECTED, 1);
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        chk("err_sync_clear", oERR_UNEXPECTED, 0);
        mul_en = 1'b1;
        tick();

        // Asynchronous reset with one result queued and two in flight.
        iRES_BUSY = 1'b1;
        send_op(36'h3ff000000, 36'h3ff000000, 36'h0, 3'b000, 0);
        repeat (4) tick();
        chk("async_queued", oRES_VALID, 1);
        mdl_hold = 1'b1;
        send_op(36'h3ff000000, 36'h400000000, 36'h0, 3'b000, 0);
        send_op(36'h3ff000000, 36'h401000000, 36'h0, 3'b000, 0);
        repeat (3) tick();
        chk("async_in_flight", 64'(mq.size()), 2);
        #2 iRESET = 1'b1;
        #1 check_reset_outputs();
        mq.delete();
        mdl_hold = 1'b0;
        iRES_BUSY = 1'b0;
        iRESET = 1'b0;
        tick();
        send_op(36'h3fe000000, 36'h402000000, 36'h401000000, 3'b000, 1);
        wait_drain();

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
